// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
// Contents: the arbiter state enum, the default write-buffer depth, the
// buffered-store entry type, address masks, and a doubleword compare helper.
package sram_arb_pkg;

    localparam int WBUF_DEPTH_DEF = 4;

    // Fills are doubleword aligned; stores are word aligned.
    localparam logic [31:0] DW_MASK   = 32'hFFFF_FFF8;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } wbuf_entry_t;

    // True when both addresses fall in the same 8-byte doubleword.
    function automatic logic same_dw(input logic [31:0] a, input logic [31:0] b);
        return ((a & DW_MASK) == (b & DW_MASK));
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted write buffer: circular FIFO with a count register, plus a
// parallel doubleword compare of every valid entry against a fill address.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push/push_entry push request and the entry to store (dropped when full)
//   pop             remove the head entry
//   cmp_adr         fill address for the hazard compare
//   head            oldest entry
//   full/empty      registered occupancy flags
//   hit             some valid entry shares cmp_adr's doubleword
module wbuf_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    input  logic [31:0] cmp_adr,
    output wbuf_entry_t head,
    output logic        full,
    output logic        empty,
    output logic        hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    wbuf_entry_t   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [PW-1:0] offs_s;
    logic          hit_s;

    // Qualify push/pop and compute the next occupancy.
    always_comb begin
        // A push while full is dropped even if a pop frees a slot this cycle.
        push_ok_s   = push & ~full_r;
        pop_ok_s    = pop & ~empty_r;
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers, count and registered occupancy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {64{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Hazard compare: a slot is valid when its distance from the head is
    // below the registered count, so this cycle's push is not yet included.
    always_comb begin
        hit_s  = 1'b0;
        offs_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs_s = PW'(i) - rd_ptr_r;
            if (({1'b0, offs_s} < count_r) && same_dw(mem_r[i].adr, cmp_adr)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign hit   = hit_s;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM controller port between cache miss-fill reads
// and a posted write buffer of write-through stores. Fills win unless a
// buffered store hits the fill's doubleword, in which case stores drain first.
// Optional macro SRAM_ARB_AGE_EN: after three fill grants with stores
// waiting, the next decision drains a store even without a hazard.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   rd_req/rd_adr/rd_data/rd_done  fill request side
//   wr_req/wr_adr/wr_data/wr_full  store push side; wbuf_empty status
//   sram_*                         SRAM controller port
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [31:0] rd_adr,
    output logic [63:0] rd_data,
    output logic        rd_done,
    input  logic        wr_req,
    input  logic [31:0] wr_adr,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wbuf_empty,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_adr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    arb_state_t  state_r;
    logic [63:0] rd_data_r;
    logic        rd_done_r;
    logic        sram_read_r;
    logic        sram_write_r;
    logic [31:0] sram_adr_r;
    logic [31:0] sram_wdata_r;
    logic        grant_rd_s;
    logic        grant_wr_s;
    logic        pop_s;
    logic        hit_s;
    logic        full_s;
    logic        empty_s;
    wbuf_entry_t head_s;
    wbuf_entry_t push_entry_s;
`ifdef SRAM_ARB_AGE_EN
    logic [1:0]  age_r;
`endif

    assign push_entry_s = '{adr: (wr_adr & WORD_MASK), data: wr_data};
    // The head leaves on the same edge the SRAM accepts the write.
    assign pop_s = (state_r == WR) && sram_ready;

    wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (wr_req),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .cmp_adr    (rd_adr),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .hit        (hit_s)
    );

    // IDLE decision: hazard drain, optional aging drain, fill, plain drain.
    always_comb begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
        if (state_r == IDLE) begin
            if (rd_req && hit_s) begin
                grant_wr_s = 1'b1;
`ifdef SRAM_ARB_AGE_EN
            end else if ((age_r == 2'd3) && !empty_s) begin
                grant_wr_s = 1'b1;
`endif
            end else if (rd_req) begin
                grant_rd_s = 1'b1;
            end else if (!empty_s) begin
                grant_wr_s = 1'b1;
            end else begin
                grant_rd_s = 1'b0;
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
        end
    end

    // Arbiter FSM; SRAM address/data are loaded once at grant so they stay
    // stable while the strobe is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            rd_data_r    <= 64'h0;
            rd_done_r    <= 1'b0;
            sram_read_r  <= 1'b0;
            sram_write_r <= 1'b0;
            sram_adr_r   <= 32'h0;
            sram_wdata_r <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    rd_done_r <= 1'b0;
                    if (grant_wr_s) begin
                        state_r      <= WR;
                        sram_write_r <= 1'b1;
                        sram_adr_r   <= head_s.adr;
                        sram_wdata_r <= head_s.data;
                    end else if (grant_rd_s) begin
                        state_r     <= RD;
                        sram_read_r <= 1'b1;
                        sram_adr_r  <= rd_adr & DW_MASK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (sram_ready) begin
                        state_r     <= IDLE;
                        sram_read_r <= 1'b0;
                        rd_data_r   <= sram_rdata;
                        rd_done_r   <= 1'b1;
                    end else begin
                        rd_done_r <= 1'b0;
                    end
                end
                WR: begin
                    rd_done_r <= 1'b0;
                    if (sram_ready) begin
                        state_r      <= IDLE;
                        sram_write_r <= 1'b0;
                    end else begin
                        state_r <= WR;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    rd_done_r    <= 1'b0;
                    sram_read_r  <= 1'b0;
                    sram_write_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_AGE_EN
    // Count fill grants that bypass waiting stores; any drain or an empty
    // buffer clears it. It cannot pass 3 because 3 forces a drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_r <= 2'd0;
        end else if (grant_wr_s || empty_s) begin
            age_r <= 2'd0;
        end else if (grant_rd_s) begin
            age_r <= age_r + 2'd1;
        end else begin
            age_r <= age_r;
        end
    end
`endif

    assign rd_data    = rd_data_r;
    assign rd_done    = rd_done_r;
    assign sram_read  = sram_read_r;
    assign sram_write = sram_write_r;
    assign sram_adr   = sram_adr_r;
    assign sram_wdata = sram_wdata_r;
    assign wr_full    = full_s;
    assign wbuf_empty = empty_s;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset values, single fill, hazard
// drain ordering, fill-before-store, full buffer and wrap order, fill stream
// with and without SRAM_ARB_AGE_EN, and reset during a write drain.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [31:0] rd_adr;
    logic [63:0] rd_data;
    logic        rd_done;
    logic        wr_req;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wbuf_empty;
    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_adr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int n_vec = 0;
    int n_err = 0;

    sram_port_arbiter #(.WBUF_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_adr     (rd_adr),
        .rd_data    (rd_data),
        .rd_done    (rd_done),
        .wr_req     (wr_req),
        .wr_adr     (wr_adr),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .wbuf_empty (wbuf_empty),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_adr   (sram_adr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] adr, input logic [31:0] data);
        wr_req  = 1'b1;
        wr_adr  = adr;
        wr_data = data;
        tick();
        wr_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rd_req = 1'b0; rd_adr = 32'h0; wr_req = 1'b0;
        wr_adr = 32'h0; wr_data = 32'h0; sram_rdata = 64'h0; sram_ready = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_read",  {63'h0, sram_read},  64'h0);
        chk("rst_write", {63'h0, sram_write}, 64'h0);
        chk("rst_adr",   {32'h0, sram_adr},   64'h0);
        chk("rst_rdata", rd_data,             64'h0);
        chk("rst_done",  {63'h0, rd_done},    64'h0);
        chk("rst_full",  {63'h0, wr_full},    64'h0);
        chk("rst_empty", {63'h0, wbuf_empty}, 64'h1);
        rst = 1'b1;
        tick();

        // Single fill, ready three cycles after the strobe rises
        rd_req = 1'b1; rd_adr = 32'h0000_0108;
        tick();
        chk("f1_read", {63'h0, sram_read}, 64'h1);
        chk("f1_adr",  {32'h0, sram_adr},  64'h0000_0108);
        tick(); tick();
        chk("f1_hold_adr", {32'h0, sram_adr}, 64'h0000_0108);
        chk("f1_no_done",  {63'h0, rd_done},  64'h0);
        sram_ready = 1'b1; sram_rdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        chk("f1_done",  {63'h0, rd_done},   64'h1);
        chk("f1_data",  rd_data,            64'hDEAD_BEEF_0123_4567);
        chk("f1_rdoff", {63'h0, sram_read}, 64'h0);
        rd_req = 1'b0; sram_ready = 1'b0;
        tick();
        chk("f1_pulse", {63'h0, rd_done}, 64'h0);

        // Hazard: store to 0x204 must drain before fill of 0x200
        push(32'h0000_0204, 32'hA5A5_0001);
        chk("hz_nonempty", {63'h0, wbuf_empty}, 64'h0);
        rd_req = 1'b1; rd_adr = 32'h0000_0200;
        tick();
        chk("hz_write", {63'h0, sram_write}, 64'h1);
        chk("hz_read",  {63'h0, sram_read},  64'h0);
        chk("hz_adr",   {32'h0, sram_adr},   64'h0000_0204);
        chk("hz_wdata", {32'h0, sram_wdata}, 64'hA5A5_0001);
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        chk("hz_empty", {63'h0, wbuf_empty}, 64'h1);
        chk("hz_gap",   {63'h0, sram_read},  64'h0);
        tick();
        chk("hz_fill",     {63'h0, sram_read}, 64'h1);
        chk("hz_fill_adr", {32'h0, sram_adr},  64'h0000_0200);
        sram_ready = 1'b1; sram_rdata = 64'h1111_2222_3333_4444;
        tick();
        chk("hz_data", rd_data, 64'h1111_2222_3333_4444);
        rd_req = 1'b0; sram_ready = 1'b0;
        tick();

        // No hazard: fill of 0x800 goes ahead of buffered store to 0x400
        push(32'h0000_0400, 32'hCAFE_0400);
        rd_req = 1'b1; rd_adr = 32'h0000_0800;
        tick();
        chk("nh_read",  {63'h0, sram_read},  64'h1);
        chk("nh_write", {63'h0, sram_write}, 64'h0);
        chk("nh_adr",   {32'h0, sram_adr},   64'h0000_0800);
        sram_ready = 1'b1; sram_rdata = 64'h0800_0800_0800_0800;
        tick();
        chk("nh_done", {63'h0, rd_done}, 64'h1);
        rd_req = 1'b0; sram_ready = 1'b0;
        tick();
        chk("nh_drain",  {63'h0, sram_write}, 64'h1);
        chk("nh_dadr",   {32'h0, sram_adr},   64'h0000_0400);
        chk("nh_wdata",  {32'h0, sram_wdata}, 64'hCAFE_0400);
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        chk("nh_empty", {63'h0, wbuf_empty}, 64'h1);

        // Full buffer while a long fill holds the port; slots wrap (2,3,0,1)
        rd_req = 1'b1; rd_adr = 32'h0000_1000;
        tick();
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_3000 + 32'(4 * i), 32'hD000_0000 + 32'(i));
        end
        chk("full_set", {63'h0, wr_full}, 64'h1);
        push(32'h0000_3010, 32'hDEAD_0005);
        chk("full_drop", {63'h0, wr_full}, 64'h1);
        sram_ready = 1'b1; sram_rdata = 64'h1000;
        tick();
        rd_req = 1'b0; sram_ready = 1'b0;
        tick();
        chk("full_d0_adr",  {32'h0, sram_adr},   64'h0000_3000);
        chk("full_d0_data", {32'h0, sram_wdata}, 64'hD000_0000);
        // Pop and push on the same edge while full: push is ignored
        wr_req = 1'b1; wr_adr = 32'h0000_5000; wr_data = 32'hBEEF_BEEF;
        sram_ready = 1'b1;
        tick();
        wr_req = 1'b0; sram_ready = 1'b0;
        chk("full_clear", {63'h0, wr_full}, 64'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("wrap_adr",  {32'h0, sram_adr},   {32'h0, 32'h0000_3000 + 32'(4 * i)});
            chk("wrap_data", {32'h0, sram_wdata}, {32'h0, 32'hD000_0000 + 32'(i)});
            sram_ready = 1'b1;
            tick();
            sram_ready = 1'b0;
        end
        chk("wrap_empty", {63'h0, wbuf_empty}, 64'h1);
        tick();
        chk("wrap_no_extra", {63'h0, sram_write}, 64'h0);

        // Fill stream with one store waiting
        rd_req = 1'b1; rd_adr = 32'h0000_7000;
        tick();
        push(32'h0000_6000, 32'h6666_6666);
        for (int k = 0; k < 4; k++) begin
            sram_ready = 1'b1; sram_rdata = 64'(k);
            tick();
            chk("st_done", {63'h0, rd_done}, 64'h1);
            sram_ready = 1'b0;
            tick();
            if (k < 3) begin
                chk("st_regrant", {63'h0, sram_read}, 64'h1);
            end
        end
`ifdef SRAM_ARB_AGE_EN
        chk("age_wr",  {63'h0, sram_write}, 64'h1);
        chk("age_rd",  {63'h0, sram_read},  64'h0);
        chk("age_adr", {32'h0, sram_adr},   64'h0000_6000);
        rd_req = 1'b0; sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
`else
        chk("strict_rd", {63'h0, sram_read},  64'h1);
        chk("strict_wr", {63'h0, sram_write}, 64'h0);
        rd_req = 1'b0; sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        tick();
        chk("strict_drain", {63'h0, sram_write}, 64'h1);
        chk("strict_adr",   {32'h0, sram_adr},   64'h0000_6000);
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
`endif
        chk("st_empty", {63'h0, wbuf_empty}, 64'h1);
        tick();

        // Reset during a write drain with three stores buffered
        rd_req = 1'b1; rd_adr = 32'h0000_8000;
        tick();
        for (int i = 0; i < 3; i++) begin
            push(32'h0000_9000 + 32'(4 * i), 32'h9000_0000 + 32'(i));
        end
        sram_ready = 1'b1;
        tick();
        rd_req = 1'b0; sram_ready = 1'b0;
        tick();
        chk("rw_write", {63'h0, sram_write}, 64'h1);
        rst = 1'b0;
        #1;
        chk("rw_write0", {63'h0, sram_write}, 64'h0);
        chk("rw_read0",  {63'h0, sram_read},  64'h0);
        chk("rw_empty",  {63'h0, wbuf_empty}, 64'h1);
        chk("rw_rdata",  rd_data,             64'h0);
        chk("rw_adr",    {32'h0, sram_adr},   64'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_quiet", {62'h0, sram_write, sram_read}, 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single SRAM controller port between the data cache's miss-fill reads and a posted write buffer fed by the cache's write-through stores. Stores are queued in a small FIFO and drained to SRAM when no fill is pending. Fills have priority except when a buffered store targets the same doubleword, which forces a drain first to preserve read-after-write order. The block sits between the cache controller and the SRAM controller, and all SRAM traffic passes through it.

## Interface
- WBUF_DEPTH, 4, write buffer entries; power of two, range 2..16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rd_req  in  1  fill request; held high until rd_done
- rd_adr  in  32  fill address; bits [2:0] are ignored (doubleword aligned)
- rd_data  out  64  fill data, registered, valid when rd_done is high
- rd_done  out  1  one-cycle pulse when the fill completes
- wr_req  in  1  store push request
- wr_adr  in  32  store word address; bits [1:0] are ignored
- wr_data  in  32  store data
- wr_full  out  1  buffer full; a push is accepted only when wr_req=1 and wr_full=0
- wbuf_empty  out  1  buffer holds no entries
- sram_read  out  1  read strobe to the SRAM controller
- sram_write  out  1  write strobe to the SRAM controller
- sram_adr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  64  SRAM read data, valid when sram_ready=1
- sram_ready  in  1  completes the current SRAM transaction

## Operation
- The FSM has three states: IDLE, RD and WR. Reset enters IDLE.
- IDLE decision order, evaluated every cycle:
  1. rd_req=1 and any valid entry has adr[31:3]==rd_adr[31:3] (hazard) -> WR.
  2. rd_req=1 -> RD.
  3. Buffer non-empty -> WR.
  4. Otherwise stay in IDLE.
- RD:
  - Drive sram_read=1 and sram_adr={rd_adr[31:3],3'b000}.
  - Hold until sram_ready=1. On that edge, capture sram_rdata into rd_data, set rd_done for the next cycle, and go to IDLE.
- WR:
  - Drive sram_write=1, sram_adr={head.adr[31:2],2'b00} and sram_wdata=head.data.
  - Hold until sram_ready=1. On that edge, pop the head and go to IDLE.
- The SRAM-side address and data are stable for the whole time the strobe is high. sram_read and sram_write are never high together.
- The buffer is a circular FIFO with a count register.
  - wr_full = (count==WBUF_DEPTH); wbuf_empty = (count==0). Both are registered from count.
  - A push and a pop in the same cycle leave count unchanged.
  - A push attempted while wr_full=1 is ignored, even if a pop occurs in the same cycle.
  - Pointers wrap modulo WBUF_DEPTH.
- Hazard compare covers valid entries only. An entry pushed in the current cycle is not compared until the next cycle.
- Reset at any time:
  - The buffer is emptied and any in-flight SRAM transaction is abandoned.
  - All outputs go to 0 (rd_data=0), except wbuf_empty=1.

## Timing
- Fill grant: rd_req is sampled in IDLE at cycle N, and sram_read is high from cycle N+1.
- If sram_ready is high in cycle N+k, rd_done pulses in cycle N+k+1. Minimum fill latency is 2 cycles after the IDLE decision.
- Write drain: sram_write is high from the cycle after the IDLE decision. The pop occurs on the sram_ready edge.
- Every transaction returns to IDLE for exactly one cycle, so there is a 1-cycle gap between back-to-back SRAM transactions.
- Push latency: an accepted push is visible in count and the hazard compare the next cycle.

## Configuration
- SRAM_ARB_AGE_EN defined:
  - A 2-bit age counter increments on each RD grant made while the buffer is non-empty.
  - The counter clears on any WR grant or when the buffer is empty.
  - When the counter equals 3, the next IDLE decision grants WR, even if rd_req=1 with no hazard.
- SRAM_ARB_AGE_EN undefined: strict read priority (rules 1–4 only). A continuous stream of fills can starve stores; wr_full back-pressures the writer.

## Structure
- Package sram_arb_pkg contains:
  - the state enum (IDLE, RD, WR);
  - the WBUF_DEPTH default;
  - the wbuf_entry_t struct {adr[31:0], data[31:0]}.
- One sub-module, wbuf_fifo, implements the FIFO storage, pointers and count, and the parallel doubleword hazard compare (output hit). The arbiter FSM and the SRAM muxing stay in the top module.

## Test plan
- Reset with rst=0 during WR with count=3 -> all strobes 0, wbuf_empty=1, state IDLE; after release, no SRAM write occurs.
- Single fill: rd_req, rd_adr=0x0000_0108, sram_ready 3 cycles after the strobe -> sram_adr=0x0000_0108, rd_data=sram_rdata, one rd_done pulse.
- Hazard: push a store to 0x0000_0204, then request a fill of 0x0000_0200 -> the WR drain completes before sram_read rises.
- No hazard: buffer holds 0x0000_0400 and rd_adr=0x0000_0800 -> RD is granted first, then the store drains after rd_done.
- Fill the buffer to 4 entries -> wr_full=1 and a 5th push is dropped. Do a simultaneous pop and push at full -> count becomes 3 and the push is ignored. Drain order matches push order across pointer wrap.
- With SRAM_ARB_AGE_EN defined, buffer non-empty, rd_req held high for 4 fills -> a WR grant occurs before the 5th fill. With it undefined, all fills are granted before any WR.
